// File: rtl/col_norm_init_pkg.sv
// Shared widths, FSM encoding and helpers for the column-norm init block.
package col_norm_init_pkg;

  localparam int WL         = 16;            // signed width of one H element
  localparam int COLNORM_WL = 16;            // unsigned width of one column norm
  localparam int ACC_WL     = 2*WL + 3;      // full-precision accumulator width
  localparam int NUM_LANES  = 8;             // columns, one accumulator each
  localparam int NUM_ROWS   = 8;
  localparam int NUM_ELEM   = NUM_LANES * NUM_ROWS;
  localparam int ROW_W      = 3;             // row counter width
  localparam int IDX_W      = 6;             // {col, row} element index
  localparam int ORDER_W    = 3 * NUM_LANES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered result bundle handed downstream.
  typedef struct packed {
    logic [NUM_LANES-1:0][COLNORM_WL-1:0] norm;
    logic [ORDER_W-1:0]                   order;
  } res_t;

  // Identity column order: slot i holds column index i.
  function automatic logic [ORDER_W-1:0] identity_order();
    logic [ORDER_W-1:0] o;
    o = '0;
    for (int i = 0; i < NUM_LANES; i++) o[3*i +: 3] = 3'(i);
    return o;
  endfunction

endpackage

// File: rtl/col_norm_init_col_sq_acc.sv
// One column lane: signed square-accumulate with shift-and-saturate view of
// the accumulator value that the current update would produce.
module col_sq_acc
  import col_norm_init_pkg::*;
#(
  parameter int NORM_SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic signed [WL-1:0]  x,
  output logic [COLNORM_WL-1:0] norm_nxt
);

  logic signed [2*WL-1:0] xe;
  logic signed [2*WL-1:0] sq_s;
  logic [ACC_WL-1:0]      acc;
  logic [ACC_WL-1:0]      acc_nxt;
  logic [ACC_WL-1:0]      shifted;

  // Square is taken at 2*WL so (-2^(WL-1))^2 is still representable and positive.
  assign xe      = {{WL{x[WL-1]}}, x};
  assign sq_s    = xe * xe;
  assign acc_nxt = acc + {3'b000, sq_s};

  // Norm is derived from acc_nxt so the top can latch it on the last row's edge.
  assign shifted  = acc_nxt >> NORM_SHIFT;
  assign norm_nxt = (shifted >= (ACC_WL'(1) << COLNORM_WL)) ? '1 : shifted[COLNORM_WL-1:0];

  // Accumulator: cleared on matrix load, summed once per row while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end

endmodule

// File: rtl/col_norm_init.sv
// Initial squared column norms of the 8x8 real channel matrix plus identity
// column order, one matrix row per cycle across 8 parallel lanes.
module col_norm_init
  import col_norm_init_pkg::*;
#(
  parameter int NORM_SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ELEM*WL-1:0]        Hmatrix_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_ELEM*WL-1:0]        Hmatrix_o,
  output logic [NUM_LANES*COLNORM_WL-1:0] colnorm_o,
  output logic [ORDER_W-1:0]            colorder_o
);

  state_t                               state, state_nxt;
  logic [ROW_W-1:0]                     row_q;
  logic [NUM_ELEM-1:0][WL-1:0]          h_q;
  logic [NUM_ELEM-1:0][WL-1:0]          hout_q;
  logic [NUM_LANES-1:0][COLNORM_WL-1:0] norm_nxt;
  res_t                                 res_q;
  logic                                 out_valid_q;
  logic                                 load;
  logic                                 acc_en;
  logic                                 last;

  // Handshake and next-state decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    load   = in_valid && in_ready;
    acc_en = (state == S_ACC);
    last   = acc_en && (row_q == ROW_W'(NUM_ROWS-1));
    case (state)
      S_IDLE: if (load) state_nxt = S_ACC;
      S_ACC:  if (last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = load ? S_ACC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Input matrix capture and row walk; row wraps to 0 after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      row_q <= '0;
    end else if (load) begin
      h_q   <= Hmatrix_i;
      row_q <= '0;
    end else if (acc_en) begin
      row_q <= row_q + 1'b1;
    end
  end

  // Lanes read element (row_q, c), which sits at flat index 8c+row_q.
  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    logic [IDX_W-1:0] idx;
    assign idx = {3'(c), row_q};
    col_sq_acc #(.NORM_SHIFT(NORM_SHIFT)) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (load),
      .en       (acc_en),
      .x        (h_q[idx]),
      .norm_nxt (norm_nxt[c])
    );
  end

  // Output registers: result latched on the last-row edge, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hout_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt == S_DONE);
      if (last) begin
        hout_q     <= h_q;
        res_q.norm <= norm_nxt;
      end
      if (load) res_q.order <= identity_order();
    end
  end

  assign out_valid  = out_valid_q;
  assign Hmatrix_o  = hout_q;
  assign colnorm_o  = res_q.norm;
  assign colorder_o = res_q.order;

endmodule
